// File: rtl/spi_ram_slave_burst.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ram_slave_burst
//  Description : SPI slave (system clock doubles as bit clock) in front of a
//                single-port RAM. Two-bit commands select write-address,
//                write-data, read-address or read-burst. Commands chain within
//                one SS_n frame, data phases auto-increment the address with
//                wrap, and an early SS_n rise raises a one-cycle abort pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_slave_burst #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int AUTO_INC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic frame_abort
);

  localparam int c_SH_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int c_SH_W   = (c_SH_MAX > 2) ? c_SH_MAX : 2;
  localparam int c_CNT_W  = $clog2(c_SH_W);
  localparam int c_DEPTH  = 2 ** ADDR_W;
  localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(ADDR_W - 1);
  localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CMD      = 3'd1,
    S_WR_ADDR  = 3'd2,
    S_WR_DATA  = 3'd3,
    S_RD_ADDR  = 3'd4,
    S_RD_FETCH = 3'd5,
    S_RD_DATA  = 3'd6
  } state_t;

  logic [DATA_W-1:0] r_mem [0:c_DEPTH-1];

  state_t              r_state,     w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt,       w_cnt_nxt;
  logic [c_SH_W-2:0]   r_shift,     w_shift_nxt;
  logic                r_cmd1,      w_cmd1_nxt;
  logic                r_have_cmd1, w_have_cmd1_nxt;
  logic [ADDR_W-1:0]   r_wr_addr,   w_wr_addr_nxt;
  logic [ADDR_W-1:0]   r_rd_addr,   w_rd_addr_nxt;
  logic                r_wr_pend,   w_wr_pend_nxt;
  logic [DATA_W-1:0]   r_wr_data,   w_wr_data_nxt;
  logic [DATA_W-1:0]   r_word,      w_word_nxt;
  logic                r_miso,      w_miso_nxt;
  logic                r_abort,     w_abort_nxt;

  // Incoming serial bit appended to everything shifted so far this phase
  logic [c_SH_W-1:0]   w_shift_in;
  // A read of the address being written this cycle must see the new word
  logic                w_bypass;

  assign w_shift_in  = {r_shift, MOSI};
  assign w_bypass    = r_wr_pend && (r_wr_addr == r_rd_addr);
  assign MISO        = r_miso;
  assign busy        = (r_state != S_IDLE);
  assign frame_abort = r_abort;

  // Next-state and datapath decode; every target holds its value unless a state acts on it
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_shift_nxt     = r_shift;
    w_cmd1_nxt      = r_cmd1;
    w_have_cmd1_nxt = r_have_cmd1;
    w_rd_addr_nxt   = r_rd_addr;
    w_wr_data_nxt   = r_wr_data;
    w_word_nxt      = r_word;
    w_wr_pend_nxt   = 1'b0;
    w_miso_nxt      = 1'b0;
    w_abort_nxt     = 1'b0;
    // A latched write retires this cycle and advances the write pointer
    w_wr_addr_nxt   = (r_wr_pend && (AUTO_INC != 0)) ? r_wr_addr + 1'b1 : r_wr_addr;

    if ((r_state != S_IDLE) && SS_n) begin
      // Frame end: drop any partial word, flag it if bits were already in flight
      w_state_nxt     = S_IDLE;
      w_cnt_nxt       = '0;
      w_have_cmd1_nxt = 1'b0;
      case (r_state)
        S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_DATA: w_abort_nxt = (r_cnt != '0);
        S_CMD:                                      w_abort_nxt = r_have_cmd1;
        default:                                    w_abort_nxt = 1'b0;
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!SS_n) begin
            w_cmd1_nxt      = MOSI;
            w_have_cmd1_nxt = 1'b1;
            w_state_nxt     = S_CMD;
          end
        end
        S_CMD: begin
          if (r_have_cmd1) begin
            w_have_cmd1_nxt = 1'b0;
            w_cnt_nxt       = '0;
            case ({r_cmd1, MOSI})
              2'b00:   w_state_nxt = S_WR_ADDR;
              2'b01:   w_state_nxt = S_WR_DATA;
              2'b10:   w_state_nxt = S_RD_ADDR;
              default: w_state_nxt = S_RD_FETCH;
            endcase
          end else begin
            // Chained command: first of its two bits
            w_cmd1_nxt      = MOSI;
            w_have_cmd1_nxt = 1'b1;
          end
        end
        S_WR_ADDR: begin
          w_shift_nxt = w_shift_in[c_SH_W-2:0];
          if (r_cnt == c_ADDR_LAST) begin
            w_wr_addr_nxt = w_shift_in[ADDR_W-1:0];
            w_cnt_nxt     = '0;
            w_state_nxt   = S_CMD;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_WR_DATA: begin
          w_shift_nxt = w_shift_in[c_SH_W-2:0];
          if (r_cnt == c_DATA_LAST) begin
            // Word complete: commit next cycle while the next word starts shifting
            w_wr_pend_nxt = 1'b1;
            w_wr_data_nxt = w_shift_in[DATA_W-1:0];
            w_cnt_nxt     = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_RD_ADDR: begin
          w_shift_nxt = w_shift_in[c_SH_W-2:0];
          if (r_cnt == c_ADDR_LAST) begin
            w_rd_addr_nxt = w_shift_in[ADDR_W-1:0];
            w_cnt_nxt     = '0;
            w_state_nxt   = S_CMD;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_RD_FETCH: begin
          w_word_nxt  = w_bypass ? r_wr_data : r_mem[r_rd_addr];
          w_cnt_nxt   = '0;
          w_state_nxt = S_RD_DATA;
        end
        S_RD_DATA: begin
          w_miso_nxt = r_word[DATA_W-1];
          w_word_nxt = r_word << 1;
          if (r_cnt == c_DATA_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_RD_FETCH;
            if (AUTO_INC != 0) begin
              w_rd_addr_nxt = r_rd_addr + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and datapath registers; reset wins over any frame activity
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_cmd1      <= 1'b0;
      r_have_cmd1 <= 1'b0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_wr_pend   <= 1'b0;
      r_wr_data   <= '0;
      r_word      <= '0;
      r_miso      <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_cmd1      <= w_cmd1_nxt;
      r_have_cmd1 <= w_have_cmd1_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_wr_pend   <= w_wr_pend_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_word      <= w_word_nxt;
      r_miso      <= w_miso_nxt;
      r_abort     <= w_abort_nxt;
    end
  end

  // RAM write port; contents survive reset but a reset cycle blocks the commit
  always_ff @(posedge clk) begin
    if (!rst && r_wr_pend) begin
      r_mem[r_wr_addr] <= r_wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_slave_burst.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_ram_slave_burst
//  Description : Self-checking bench. Drives one SPI pin set into two copies
//                of the slave (address increment on and off) and compares the
//                read-back words and status pins with word-level RAM models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_ram_slave_burst;

  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  logic SS_n;
  logic MOSI;
  logic miso_i, busy_i, abort_i;
  logic miso_h, busy_h, abort_h;

  spi_ram_slave_burst #(.ADDR_W(AW), .DATA_W(DW), .AUTO_INC(1)) u_dut_inc (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(miso_i), .busy(busy_i), .frame_abort(abort_i)
  );

  spi_ram_slave_burst #(.ADDR_W(AW), .DATA_W(DW), .AUTO_INC(0)) u_dut_hold (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(miso_h), .busy(busy_h), .frame_abort(abort_h)
  );

  always #5 clk = ~clk;

  // Expected RAM contents for each copy
  logic [DW-1:0] mem_i [0:(2**AW)-1];
  logic [DW-1:0] mem_h [0:(2**AW)-1];
  logic [DW-1:0] wbuf  [0:7];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = b;
  endtask

  task automatic send_word(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic end_frame(input logic exp_abort, input string tag);
    @(negedge clk);
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
    chk({tag, " abort_inc"}, abort_i, exp_abort);
    chk({tag, " abort_hold"}, abort_h, exp_abort);
    chk({tag, " busy_inc"}, busy_i, 0);
    chk({tag, " busy_hold"}, busy_h, 0);
    chk({tag, " miso_idle"}, {miso_i, miso_h}, 0);
    @(negedge clk);
    chk({tag, " abort_pulse_end"}, {abort_i, abort_h}, 0);
  endtask

  // "00 addr 01 w0 w1 ..." then SS_n high; model applies the words afterwards
  task automatic write_frame(input logic [AW-1:0] addr, input int n, input string tag);
    logic [AW-1:0] a;
    send_word(0, 2);
    send_word(addr, AW);
    send_word(1, 2);
    for (int i = 0; i < n; i++) send_word(wbuf[i], DW);
    end_frame(1'b0, tag);
    for (int i = 0; i < n; i++) begin
      a = addr + AW'(i);
      mem_i[a]    = wbuf[i];
      mem_h[addr] = wbuf[i];
    end
  endtask

  // "10 addr 11" then collect n words, each preceded by one zero gap cycle
  task automatic read_frame(input logic [AW-1:0] addr, input int n, input string tag);
    logic [DW-1:0] ri, rh;
    logic [AW-1:0] a;
    send_word(2, 2);
    send_word(addr, AW);
    send_word(3, 2);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, " gap"}, {miso_i, miso_h}, 0);
      ri = '0;
      rh = '0;
      for (int b = 0; b < DW; b++) begin
        @(negedge clk);
        ri = {ri[DW-2:0], miso_i};
        rh = {rh[DW-2:0], miso_h};
      end
      a = addr + AW'(i);
      chk({tag, " word_inc"}, ri, mem_i[a]);
      chk({tag, " word_hold"}, rh, mem_h[addr]);
    end
    end_frame(1'b0, tag);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] ra;
    int            rn;

    rst  = 1'b1;
    SS_n = 1'b1;
    MOSI = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset miso", {miso_i, miso_h}, 0);
    chk("reset busy", {busy_i, busy_h}, 0);
    chk("reset abort", {abort_i, abort_h}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Give every location a known value
    for (int a = 0; a < 2**AW; a++) begin
      wbuf[0] = DW'($urandom);
      write_frame(AW'(a), 1, "preload");
    end

    // Single write and read-back
    wbuf[0] = 8'hA5;
    write_frame(8'h10, 1, "single_wr");
    read_frame(8'h10, 1, "single_rd");

    // Burst crossing the top of the address space
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    write_frame(8'hFE, 3, "wrap_wr");
    read_frame(8'hFE, 3, "wrap_rd");

    // Held-address behaviour and untouched neighbour
    wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03;
    write_frame(8'h40, 3, "hold_wr");
    read_frame(8'h40, 3, "hold_rd");
    read_frame(8'h41, 1, "hold_next");

    // Abort five bits into a data word: RAM keeps its old value
    wbuf[0] = 8'h5A;
    write_frame(8'h20, 1, "abort_pre");
    send_word(0, 2);
    send_word(8'h20, AW);
    send_word(1, 2);
    send_word(5'b10101, 5);
    end_frame(1'b1, "abort_wr");
    read_frame(8'h20, 1, "abort_rd");

    // Abort after a single command bit
    send_bit(1'b1);
    end_frame(1'b1, "abort_cmd");

    // Abort two bits into a read word
    send_word(2, 2);
    send_word(8'h20, AW);
    send_word(3, 2);
    repeat (3) @(negedge clk);
    end_frame(1'b1, "abort_rd_data");

    // Reset held two cycles in the middle of a read
    send_word(2, 2);
    send_word(8'h00, AW);
    send_word(3, 2);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rd miso", {miso_i, miso_h}, 0);
    chk("rst_rd busy", {busy_i, busy_h}, 0);
    chk("rst_rd abort", {abort_i, abort_h}, 0);
    rst  = 1'b0;
    SS_n = 1'b1;
    @(negedge clk);
    read_frame(8'h00, 1, "rst_rd_after");

    // Reset on the last data bit: no write, write pointer back to zero
    send_word(0, 2);
    send_word(8'h30, AW);
    send_word(1, 2);
    send_word(7'h7F, 7);
    @(negedge clk);
    MOSI = 1'b1;
    rst  = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    SS_n = 1'b1;
    @(negedge clk);
    send_word(1, 2);
    send_word(8'hC3, DW);
    end_frame(1'b0, "rst_wr_data_only");
    mem_i[0] = 8'hC3;
    mem_h[0] = 8'hC3;
    read_frame(8'h30, 1, "rst_wr_untouched");
    read_frame(8'h00, 1, "rst_wr_addr0");

    // Random bursts
    for (int t = 0; t < 12; t++) begin
      rn = $urandom_range(1, 4);
      for (int i = 0; i < rn; i++) wbuf[i] = DW'($urandom);
      ra = AW'($urandom_range(0, 2**AW - 1));
      write_frame(ra, rn, "rand_wr");
      rn = $urandom_range(1, 4);
      if (t % 2 == 0) ra = AW'($urandom_range(0, 2**AW - 1));
      read_frame(ra, rn, "rand_rd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
